spi_exe_unit_2: RTL and testbench
=================================

# spi_exe_unit_2

Parametrised SPI-attached arithmetic/logic execution unit, next generation of the SPI execution unit. An SPI master shifts in two M-bit operands and an 8-bit operation byte on MOSI. The block computes the result and shifts the M-bit result plus a 4-bit flag nibble back on MISO. New in this generation:
- operand width M is generic;
- accumulate mode;
- defined illegal-opcode response;
- chip-select abort at any point in the frame;
- back-to-back frames without an idle gap.

## Interface
Parameters:
- M, 8, operand/result width in bits; legal range 4..32.

Ports:
- i_sclk  in  1  SPI serial clock; the only clock; all logic on rising edge.
- i_rst  in  1  reset; synchronous, active-high.
- i_cs  in  1  chip select, active-low, sampled on the rising edge of i_sclk.
- i_mosi  in  1  serial data in, MSB first, sampled on the rising edge of i_sclk.
- o_miso  out  1  serial data out, registered, MSB first.
- o_busy  out  1  registered; high in every state except IDLE.

## Operation
Input frame, MSB first:
- A: M bits.
- B: M bits.
- OP: 8 bits.
  - OP[7:4]: opcode.
  - OP[3]: ACC.
  - OP[2:0]: reserved, ignored.

Output frame: R (M bits), then F (4 bits), MSB first. F = {Z, N, C, V}.

State machine, one state transition per rising edge:
- IDLE: when i_cs=0, capture i_mosi as A bit M-1 and go to LOAD_A with bit count 1. When i_cs=1, stay in IDLE.
- LOAD_A → LOAD_B → LOAD_OP: each state captures its field.
  - The edge that captures a field's last bit moves to the next state.
  - A is complete after M edges, B after M edges, OP after 8 edges.
- EXEC: one edge.
  - Compute R and F.
  - Write R into the accumulator register.
  - Load {R, F} into the output shifter.
  - Drive R[M-1] on o_miso.
  - Go to SHIFT_OUT.
- SHIFT_OUT: shifts the remaining M+3 bits, one per edge. On the next edge, o_miso returns to 0 and the state goes to IDLE. i_mosi is ignored in this state.

Abort:
- i_cs=1 on any edge in LOAD_A, LOAD_B, LOAD_OP, EXEC or SHIFT_OUT sends the state to IDLE and sets o_miso to 0.
- Partially received fields are discarded.
- The accumulator changes only if EXEC already completed.

Operand selection: effective A is the accumulator when OP[3]=1, otherwise the received A.

Opcodes (all arithmetic is modulo 2^M):
- 0 ADD: R = A+B. C = carry out of bit M-1. V = signed overflow.
- 1 SUB: R = A−B. C = 1 when A<B unsigned (borrow). V = signed overflow.
- 2 AND, 3 OR, 4 XOR: C=0, V=0.
- 5 NOT: R = ~A; B is ignored. C=0, V=0.
- 6 SHL: R = A << B. R=0 when B≥M. C=0, V=0.
- 7 SHR: R = A >> B, logical. R=0 when B≥M. C=0, V=0.
- 8–15 illegal: R = all-ones, F = 4'b1111. The accumulator is loaded with all-ones.

Flag rules for opcodes 0–7: Z = (R==0), N = R[M-1].

Reset (i_rst=1 at a rising edge), regardless of state or i_cs:
- state = IDLE;
- A, B, OP, accumulator and output shifter = 0;
- o_miso = 0, o_busy = 0.

## Timing
- Let edge E be the edge that captures OP bit 0. E moves the state to EXEC.
- After edge E+1: o_miso = R[M-1].
- After edge E+1+k: o_miso = bit k of {R, F}, for k = 0..M+3.
- After edge E+M+5: o_miso = 0 and state = IDLE.
- Full transaction: 2M+8 input edges, then 1 EXEC edge, then M+4 output edges (the EXEC edge also drives the first output bit).
- Back-to-back frames: if i_cs stays low, the first edge in IDLE already captures bit M-1 of the next A. There is exactly one idle edge between frames.
- o_busy rises on the edge that leaves IDLE and falls on the edge that enters IDLE.
- Simultaneous i_rst and i_cs activity: reset wins.

## Test plan
- Reset, then ADD (M=8): A=0x7F, B=0x01, OP=0x00 → MISO = 1000_0000 then 0101 (R=0x80, V=1, N=1), then o_miso=0. Check o_busy timing.
- SUB: A=0x03, B=0x05, OP=0x10 → R=0xFE, F=0110 (N=1, C=1). Then, back-to-back with i_cs held low, SHL: A=0x81, B=0x09, OP=0x60 → R=0x00, F=1000.
- Accumulate: ADD 0x7F+0x01 (R=0x80), then a frame with A=0x55, B=0x01, OP=0x08 → R=0x81, F=0100 (A=0x55 ignored).
- Illegal opcode: OP=0x90 → R=0xFF, F=1111. A following OP=0x58 (NOT with ACC) → R=0x00, F=1000.
- Abort and reset:
  - Raise i_cs after 10 input bits → IDLE next edge, o_miso=0. Next full frame computes correctly.
  - i_rst mid-SHIFT_OUT → o_miso=0, o_busy=0. ACC-mode ADD with B=0x02 → R=0x02.
- M=16: A=0x8000, B=0x8000, ADD → R=0x0000, F=1011 (Z, C, V), 20 output bits.

Source files
------------

// File: rtl/spi_exe_unit_2.sv
// spi_exe_unit_2: SPI-attached ALU. It shifts in A (M bits), B (M bits) and OP (8 bits), MSB first.
// It then shifts out R (M bits) and F={Z,N,C,V}, MSB first.
// Latency: 1 EXEC edge after the last OP bit. On that edge o_miso already carries R[M-1].
// Backpressure: none. The master owns i_sclk, and i_cs high aborts the frame on any edge.
// Ports: i_sclk (only clock), i_rst (sync, active-high), i_cs (active-low), i_mosi,
//        o_miso (registered), o_busy (registered, high outside IDLE).
module spi_exe_unit_2 #(
  parameter int M = 8
) (
  input  logic i_sclk,
  input  logic i_rst,
  input  logic i_cs,
  input  logic i_mosi,
  output logic o_miso,
  output logic o_busy
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_LOAD_A  = 3'd1;
  localparam logic [2:0] S_LOAD_B  = 3'd2;
  localparam logic [2:0] S_LOAD_OP = 3'd3;
  localparam logic [2:0] S_EXEC    = 3'd4;
  localparam logic [2:0] S_SHIFT   = 3'd5;

  localparam int CW = $clog2(M + 4) + 1;
  localparam logic [CW-1:0] LP_FIELD_LAST = CW'(M - 1);
  localparam logic [CW-1:0] LP_OP_LAST    = CW'(7);
  localparam logic [CW-1:0] LP_SH_LAST    = CW'(M + 3);

  logic [2:0]    r_state;
  logic [CW-1:0] r_cnt;
  logic [M-1:0]  r_a;
  logic [M-1:0]  r_b;
  logic [7:0]    r_op;
  logic [M-1:0]  r_acc;
  logic [M+3:0]  r_sh;
  logic          r_miso;
  logic          r_busy;

  logic [2:0]    w_state_nxt;
  logic [M-1:0]  w_a_eff;
  logic [M:0]    w_sum;
  logic [M:0]    w_diff;
  logic          w_shamt_big;
  logic [M-1:0]  w_res;
  logic          w_c;
  logic          w_v;
  logic          w_illegal;
  logic [3:0]    w_flags;

  assign o_miso = r_miso;
  assign o_busy = r_busy;

  // Next state. The counter compare is made on the edge that captures a field's last bit.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:    if (!i_cs) w_state_nxt = S_LOAD_A;
      S_LOAD_A:  if (i_cs) w_state_nxt = S_IDLE;
                 else if (r_cnt == LP_FIELD_LAST) w_state_nxt = S_LOAD_B;
      S_LOAD_B:  if (i_cs) w_state_nxt = S_IDLE;
                 else if (r_cnt == LP_FIELD_LAST) w_state_nxt = S_LOAD_OP;
      S_LOAD_OP: if (i_cs) w_state_nxt = S_IDLE;
                 else if (r_cnt == LP_OP_LAST) w_state_nxt = S_EXEC;
      S_EXEC:    w_state_nxt = i_cs ? S_IDLE : S_SHIFT;
      S_SHIFT:   if (i_cs || r_cnt == LP_SH_LAST) w_state_nxt = S_IDLE;
      default:   w_state_nxt = S_IDLE;
    endcase
  end

  // ALU. The M+1-bit sum and difference expose the carry and the borrow in their top bit.
  always_comb begin
    w_a_eff     = r_op[3] ? r_acc : r_a;
    w_sum       = {1'b0, w_a_eff} + {1'b0, r_b};
    w_diff      = {1'b0, w_a_eff} - {1'b0, r_b};
    w_shamt_big = (32'(r_b) >= 32'(M));
    w_res       = '0;
    w_c         = 1'b0;
    w_v         = 1'b0;
    w_illegal   = 1'b0;
    case (r_op[7:4])
      4'd0: begin
        w_res = w_sum[M-1:0];
        w_c   = w_sum[M];
        w_v   = (w_a_eff[M-1] == r_b[M-1]) && (w_sum[M-1] != w_a_eff[M-1]);
      end
      4'd1: begin
        w_res = w_diff[M-1:0];
        w_c   = w_diff[M];
        w_v   = (w_a_eff[M-1] != r_b[M-1]) && (w_diff[M-1] != w_a_eff[M-1]);
      end
      4'd2: w_res = w_a_eff & r_b;
      4'd3: w_res = w_a_eff | r_b;
      4'd4: w_res = w_a_eff ^ r_b;
      4'd5: w_res = ~w_a_eff;
      4'd6: w_res = w_shamt_big ? '0 : (w_a_eff << r_b);
      4'd7: w_res = w_shamt_big ? '0 : (w_a_eff >> r_b);
      default: begin
        w_res     = '1;
        w_illegal = 1'b1;
      end
    endcase
    w_flags = w_illegal ? 4'hF : {(w_res == '0), w_res[M-1], w_c, w_v};
  end

  always_ff @(posedge i_sclk) begin
    if (i_rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_a     <= '0;
      r_b     <= '0;
      r_op    <= '0;
      r_acc   <= '0;
      r_sh    <= '0;
      r_miso  <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_busy  <= (w_state_nxt != S_IDLE);
      case (r_state)
        S_IDLE: begin
          r_miso <= 1'b0;
          if (!i_cs) begin
            // The first frame edge already carries A[M-1]. This allows back-to-back frames.
            r_a   <= {{(M-1){1'b0}}, i_mosi};
            r_cnt <= CW'(1);
          end
        end
        S_LOAD_A: begin
          if (i_cs) r_miso <= 1'b0;
          else begin
            r_a   <= {r_a[M-2:0], i_mosi};
            r_cnt <= (r_cnt == LP_FIELD_LAST) ? '0 : r_cnt + 1'b1;
          end
        end
        S_LOAD_B: begin
          if (i_cs) r_miso <= 1'b0;
          else begin
            r_b   <= {r_b[M-2:0], i_mosi};
            r_cnt <= (r_cnt == LP_FIELD_LAST) ? '0 : r_cnt + 1'b1;
          end
        end
        S_LOAD_OP: begin
          if (i_cs) r_miso <= 1'b0;
          else begin
            r_op  <= {r_op[6:0], i_mosi};
            r_cnt <= (r_cnt == LP_OP_LAST) ? '0 : r_cnt + 1'b1;
          end
        end
        S_EXEC: begin
          if (i_cs) r_miso <= 1'b0;
          else begin
            // R[M-1] goes out now. The shifter holds the remaining M+3 bits, left-aligned.
            r_acc  <= w_res;
            r_miso <= w_res[M-1];
            r_sh   <= {w_res, w_flags} << 1;
            r_cnt  <= '0;
          end
        end
        S_SHIFT: begin
          if (i_cs || r_cnt == LP_SH_LAST) r_miso <= 1'b0;
          else begin
            r_miso <= r_sh[M+3];
            r_sh   <= r_sh << 1;
            r_cnt  <= r_cnt + 1'b1;
          end
        end
        default: r_miso <= 1'b0;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_exe_unit_2.sv
// tb_spi_exe_unit_2: drives SPI frames into an M=8 and an M=16 instance.
// It compares the serial result against directed constants and an arithmetic reference model.
// Inputs are driven and outputs sampled on the falling edge of sclk.
module tb_spi_exe_unit_2;

  logic sclk = 1'b0;
  logic rst;
  logic cs8, mosi8, miso8, busy8;
  logic cs16, mosi16, miso16, busy16;

  int n_chk  = 0;
  int n_pass = 0;
  logic [31:0] acc8  = '0;
  logic [31:0] acc16 = '0;

  always #5 sclk = ~sclk;

  spi_exe_unit_2 #(.M(8)) u_dut8 (
    .i_sclk(sclk), .i_rst(rst), .i_cs(cs8), .i_mosi(mosi8),
    .o_miso(miso8), .o_busy(busy8)
  );

  spi_exe_unit_2 #(.M(16)) u_dut16 (
    .i_sclk(sclk), .i_rst(rst), .i_cs(cs16), .i_mosi(mosi16),
    .o_miso(miso16), .o_busy(busy16)
  );

  task automatic check(input string tag, input logic [35:0] got, input logic [35:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  // One sclk edge: the unselected instance is held deselected.
  task automatic step(input int sel, input logic cs, input logic mosi);
    cs8 = 1'b1; mosi8 = 1'b0; cs16 = 1'b1; mosi16 = 1'b0;
    if (sel == 8) begin cs8 = cs; mosi8 = mosi; end
    else if (sel == 16) begin cs16 = cs; mosi16 = mosi; end
    @(posedge sclk);
    @(negedge sclk);
  endtask

  function automatic logic get_miso(input int sel);
    return (sel == 8) ? miso8 : miso16;
  endfunction

  function automatic logic get_busy(input int sel);
    return (sel == 8) ? busy8 : busy16;
  endfunction

  function automatic longint sx(input longint x, input int m);
    longint one;
    one = 1;
    return (x >= (one << (m - 1))) ? x - (one << m) : x;
  endfunction

  // Reference: returns {R, F} in the low m+4 bits.
  function automatic logic [35:0] model(input int m, input logic [31:0] a, input logic [31:0] b,
                                        input logic [7:0] op, input logic [31:0] acc);
    longint one, mask, ae, bb, r, s, hi, lo;
    int opc, f;
    one  = 1;
    mask = (one << m) - 1;
    hi   = (one << (m - 1)) - 1;
    lo   = -(hi + 1);
    ae   = op[3] ? longint'(acc) : longint'(a);
    bb   = longint'(b);
    opc  = int'(op[7:4]);
    f    = 0;
    r    = 0;
    if (opc >= 8) return 36'((mask << 4) | 15);
    case (opc)
      0: begin r = ae + bb; if (r > mask) f |= 2; s = sx(ae, m) + sx(bb, m); if (s < lo || s > hi) f |= 1; end
      1: begin r = ae - bb; if (ae < bb) f |= 2; s = sx(ae, m) - sx(bb, m); if (s < lo || s > hi) f |= 1; end
      2: r = ae & bb;
      3: r = ae | bb;
      4: r = ae ^ bb;
      5: r = ~ae;
      6: r = (bb >= m) ? 0 : (ae << bb);
      default: r = (bb >= m) ? 0 : (ae >> bb);
    endcase
    r = r & mask;
    if (r == 0) f |= 8;
    if (((r >> (m - 1)) & 1) != 0) f |= 4;
    return 36'((r << 4) | longint'(f));
  endfunction

  // Full frame: 2m+8 input edges, EXEC, m+3 shift edges, final edge back to IDLE.
  // If stop_at >= 0, edge number stop_at aborts the frame, with cs high or with reset.
  task automatic frame(input string tag, input int sel, input int m,
                       input logic [31:0] a, input logic [31:0] b, input logic [7:0] op,
                       input int stop_at, input bit use_rst,
                       output logic [35:0] got, output logic [35:0] exp);
    logic [71:0] fv;
    int len;
    fv  = ({40'd0, a} << (m + 8)) | ({40'd0, b} << 8) | {64'd0, op};
    len = 3 * m + 13;
    got = '0;
    exp = model(m, a, b, op, (sel == 8) ? acc8 : acc16);
    for (int e = 0; e < len; e++) begin
      if (e == stop_at) begin
        if (use_rst) begin
          rst = 1'b1;
          step(sel, 1'b0, 1'b1);
          rst = 1'b0;
          acc8 = '0;
          acc16 = '0;
        end else begin
          step(sel, 1'b1, 1'($urandom));
        end
        check({tag, " abort miso"}, 36'(get_miso(sel)), 36'd0);
        check({tag, " abort busy"}, 36'(get_busy(sel)), 36'd0);
        return;
      end
      step(sel, 1'b0, (e < 2 * m + 8) ? fv[2 * m + 7 - e] : 1'($urandom));
      if (e == 0) check({tag, " busy rise"}, 36'(get_busy(sel)), 36'd1);
      if (e == 2 * m + 8) begin
        got = 36'(get_miso(sel));
        if (sel == 8) acc8 = exp[35:4]; else acc16 = exp[35:4];
      end else if (e > 2 * m + 8 && e < len - 1) begin
        got = {got[34:0], get_miso(sel)};
        if (e == len - 2) check({tag, " busy last bit"}, 36'(get_busy(sel)), 36'd1);
      end else if (e == len - 1) begin
        check({tag, " end miso"}, 36'(get_miso(sel)), 36'd0);
        check({tag, " end busy"}, 36'(get_busy(sel)), 36'd0);
      end
    end
  endtask

  initial begin
    logic [35:0] got, exp;
    logic [31:0] ra, rb, rmask;
    logic [7:0]  rop;
    int sel, m, stop;

    rst = 1'b1; cs8 = 1'b1; cs16 = 1'b1; mosi8 = 1'b0; mosi16 = 1'b0;
    @(negedge sclk);
    step(0, 1'b1, 1'b0);
    step(0, 1'b1, 1'b0);
    rst = 1'b0;
    step(0, 1'b1, 1'b0);
    check("reset miso8", 36'(miso8), 36'd0);
    check("reset busy8", 36'(busy8), 36'd0);
    check("reset miso16", 36'(miso16), 36'd0);
    check("reset busy16", 36'(busy16), 36'd0);

    frame("add", 8, 8, 32'h7F, 32'h01, 8'h00, -1, 1'b0, got, exp);
    check("add 7F+01", got, 36'h805);
    step(0, 1'b1, 1'b0);
    check("idle busy", 36'(busy8), 36'd0);

    frame("sub", 8, 8, 32'h03, 32'h05, 8'h10, -1, 1'b0, got, exp);
    check("sub 03-05", got, 36'hFE6);
    frame("shl b2b", 8, 8, 32'h81, 32'h09, 8'h60, -1, 1'b0, got, exp);
    check("shl by 9 back-to-back", got, 36'h008);
    step(0, 1'b1, 1'b0);

    frame("add2", 8, 8, 32'h7F, 32'h01, 8'h00, -1, 1'b0, got, exp);
    check("add 7F+01 again", got, 36'h805);
    frame("acc", 8, 8, 32'h55, 32'h01, 8'h08, -1, 1'b0, got, exp);
    check("acc add", got, 36'h814);

    frame("illegal", 8, 8, 32'h12, 32'h34, 8'h90, -1, 1'b0, got, exp);
    check("illegal op", got, 36'hFFF);
    frame("not acc", 8, 8, 32'h00, 32'h00, 8'h58, -1, 1'b0, got, exp);
    check("not acc", got, 36'h008);

    frame("cs abort", 8, 8, 32'hAA, 32'hBB, 8'h00, 10, 1'b0, got, exp);
    frame("xor", 8, 8, 32'hA5, 32'h0F, 8'h40, -1, 1'b0, got, exp);
    check("xor after abort", got, 36'hAA4);

    frame("rst shift", 8, 8, 32'h12, 32'h34, 8'h20, 28, 1'b1, got, exp);
    frame("acc after rst", 8, 8, 32'hFF, 32'h02, 8'h08, -1, 1'b0, got, exp);
    check("acc add after reset", got, 36'h020);

    frame("m16 add", 16, 16, 32'h8000, 32'h8000, 8'h00, -1, 1'b0, got, exp);
    check("m16 add 8000+8000", got, 36'h0000B);

    for (int it = 0; it < 80; it++) begin
      sel   = (it % 4 == 3) ? 16 : 8;
      m     = sel;
      rmask = (sel == 8) ? 32'hFF : 32'hFFFF;
      ra    = $urandom & rmask;
      rb    = ($urandom_range(0, 1) == 1) ? 32'($urandom_range(0, 20)) : ($urandom & rmask);
      rop   = 8'($urandom);
      stop  = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 3 * m + 12)) : -1;
      frame("rand", sel, m, ra, rb, rop, stop, 1'b0, got, exp);
      if (stop < 0) check($sformatf("rand m%0d op %02h", m, rop), got, exp);
      if ($urandom_range(0, 1) == 1) step(0, 1'b1, 1'b0);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
